// File: rtl/irq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// irq_ctrl : synchronised, masked, priority-encoded interrupt front-end for CP0
// Revision : 1.0
// ----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic             ir_ack,
  input  logic             eoi,
  output logic             ir_in,
  output logic [3:0]       irq_id
);

  localparam logic [1:0] ADDR_MASK    = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0][N_SRC-1:0] sync_q, sync_d;
  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] edge_pend_q, edge_pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  state_e           state_q, state_d;
  logic             ir_in_q, ir_in_d;
  logic [3:0]       irq_id_q, irq_id_d;

  logic [N_SRC-1:0] sync_last;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [3:0]       winner;
  logic             wr_pend;
  logic             ack_take;
  logic             unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:N_SRC];

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise      = sync_last & ~prev_q;
  // Level sources bypass the pending flop so a withdrawn line drops out as soon as it is synchronised.
  assign pend      = (mode_q & edge_pend_q) | (~mode_q & sync_last);
  assign active    = pend & mask_q;
  assign wr_pend   = cfg_we && (cfg_addr == ADDR_PENDING);
  assign ack_take  = ir_ack && (state_q == ST_REQ);

  always_comb begin
    sync_d[0] = irq_src;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    prev_d = sync_last;
  end

  always_comb begin
    clr = wr_pend ? cfg_wdata[N_SRC-1:0] : '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (ack_take && (irq_id_q == 4'(i))) begin
        clr[i] = 1'b1;
      end
    end
    edge_pend_d = mode_q & ((edge_pend_q & ~clr) | rise);
    mask_d = (cfg_we && (cfg_addr == ADDR_MASK)) ? cfg_wdata[N_SRC-1:0] : mask_q;
    mode_d = (cfg_we && (cfg_addr == ADDR_MODE)) ? cfg_wdata[N_SRC-1:0] : mode_q;
  end

  always_comb begin
    winner = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        winner = 4'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    case (state_q)
      ST_IDLE: begin
        if (active != '0) begin
          state_d  = ST_REQ;
          irq_id_d = winner;
        end
      end
      ST_REQ: begin
        if (ir_ack) begin
          state_d = ST_SERVICE;
        end else if (active == '0) begin
          state_d = ST_IDLE;
        end else begin
          irq_id_d = winner;
        end
      end
      ST_SERVICE: begin
        if (eoi) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Leaving SERVICE always lands in IDLE, so CP0 sees a low cycle before the next request.
    ir_in_d = (state_d == ST_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      prev_q      <= '0;
      edge_pend_q <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      state_q     <= ST_IDLE;
      ir_in_q     <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      edge_pend_q <= edge_pend_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      state_q     <= state_d;
      ir_in_q     <= ir_in_d;
      irq_id_q    <= irq_id_d;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK:    cfg_rdata[N_SRC-1:0] = mask_q;
      ADDR_MODE:    cfg_rdata[N_SRC-1:0] = mode_q;
      ADDR_PENDING: cfg_rdata[N_SRC-1:0] = pend;
      default: begin
        cfg_rdata[31]  = ir_in_q;
        cfg_rdata[30]  = (state_q == ST_SERVICE);
        cfg_rdata[3:0] = irq_id_q;
      end
    endcase
  end

  assign ir_in  = ir_in_q;
  assign irq_id = irq_id_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// tb_irq_ctrl : table-driven, directed and randomized checks of irq_ctrl
// against a rule-level reference model.
module tb_irq_ctrl;

  localparam int N    = 8;
  localparam int S    = 2;
  localparam int NM   = (1 << N) - 1;
  localparam int IDLE = 0;
  localparam int REQ  = 1;
  localparam int SVC  = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_src;
  logic         cfg_we;
  logic [1:0]   cfg_addr;
  logic [31:0]  cfg_wdata;
  logic [31:0]  cfg_rdata;
  logic         ir_ack;
  logic         eoi;
  logic         ir_in;
  logic [3:0]   irq_id;

  always #5 clk = ~clk;

  irq_ctrl #(.N_SRC(N), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .ir_ack    (ir_ack),
    .eoi       (eoi),
    .ir_in     (ir_in),
    .irq_id    (irq_id)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: raw-line history, pending set, config and handshake phase.
  int m_pipe [S];
  int m_prev, m_edge, m_mask, m_mode, m_state, m_id;

  function automatic int lowest(input int a);
    return $clog2(a & -a);
  endfunction

  function automatic int m_pend();
    return ((m_mode & m_edge) | (~m_mode & m_pipe[S-1])) & NM;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_mask);
      2'd1:    return 32'(m_mode);
      2'd2:    return 32'(m_pend());
      default: return {m_state == REQ, m_state == SVC, 26'd0, 4'(m_id)};
    endcase
  endfunction

  task automatic model_reset();
    for (int s = 0; s < S; s++) m_pipe[s] = 0;
    m_prev = 0; m_edge = 0; m_mask = 0; m_mode = 0; m_state = IDLE; m_id = 0;
  endtask

  task automatic model_step();
    int sync, act, rise, clr, nxt_edge;
    if (rst) begin
      model_reset();
      return;
    end
    sync = m_pipe[S-1];
    act  = m_pend() & m_mask;
    rise = sync & ~m_prev & NM;
    clr  = (cfg_we && cfg_addr == 2'd2) ? (int'(cfg_wdata) & NM) : 0;
    if (m_state == REQ && ir_ack) clr = clr | (1 << m_id);
    nxt_edge = ((m_edge & ~clr) | rise) & m_mode;
    case (m_state)
      IDLE: if (act != 0) begin m_state = REQ; m_id = lowest(act); end
      REQ: begin
        if (ir_ack) m_state = SVC;
        else if (act == 0) m_state = IDLE;
        else m_id = lowest(act);
      end
      default: if (eoi) m_state = IDLE;
    endcase
    m_edge = nxt_edge;
    if (cfg_we && cfg_addr == 2'd0) m_mask = int'(cfg_wdata) & NM;
    if (cfg_we && cfg_addr == 2'd1) m_mode = int'(cfg_wdata) & NM;
    m_prev = sync;
    for (int s = S - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
    m_pipe[0] = int'(irq_src);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } cfg_vec_t;

  cfg_vec_t vecs [7];
  logic [31:0] d;

  initial begin
    vecs[0] = '{"mask_rw",      2'd0, 32'h0000_00A5, 2'd0, 32'h0000_00A5};
    vecs[1] = '{"mode_rw",      2'd1, 32'h0000_003C, 2'd1, 32'h0000_003C};
    vecs[2] = '{"mask_trunc",   2'd0, 32'hFFFF_FF0F, 2'd0, 32'h0000_000F};
    vecs[3] = '{"cause_ro",     2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
    vecs[4] = '{"pend_w1c_nop", 2'd2, 32'h0000_00FF, 2'd2, 32'h0000_0000};
    vecs[5] = '{"mode_keeps_mask", 2'd1, 32'h0000_0000, 2'd0, 32'h0000_000F};
    vecs[6] = '{"mask_clear",   2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};

    rst = 1'b1; irq_src = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    ir_ack = 1'b0; eoi = 1'b0;
    model_reset();
    ticks(2);
    rst = 1'b0;
    tick();

    chk("reset_ir_in", 32'(ir_in), 0);
    chk("reset_irq_id", 32'(irq_id), 0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      chk($sformatf("reset_reg%0d", a), d, 0);
    end

    for (int i = 0; i < 7; i++) begin
      wr(vecs[i].waddr, vecs[i].wdata);
      rd(vecs[i].raddr, d);
      chk(vecs[i].name, d, vecs[i].exp);
    end

    // Edge source 3: four edges from first sample to ir_in.
    wr(2'd0, 32'h08); wr(2'd1, 32'h08);
    irq_src = 8'h08; tick(); irq_src = '0;
    ticks(2);
    chk("edge_ir_early", 32'(ir_in), 0);
    rd(2'd2, d); chk("edge_pend_set", d, 32'h08);
    tick();
    chk("edge_ir_in", 32'(ir_in), 1);
    chk("edge_irq_id", 32'(irq_id), 3);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    chk("ack_ir_low", 32'(ir_in), 0);
    rd(2'd2, d); chk("ack_pend_clr", d, 0);
    rd(2'd3, d); chk("ack_cause", d, 32'h4000_0003);
    eoi = 1'b1; tick(); eoi = 1'b0;
    rd(2'd3, d); chk("eoi_idle", 32'(d[31:30]), 0);

    // Priority 2 over 5, then 5 after exactly one low cycle.
    wr(2'd0, 32'hFF); wr(2'd1, 32'hFF);
    irq_src = 8'h24; tick(); irq_src = '0;
    ticks(3);
    chk("prio_ir_in", 32'(ir_in), 1);
    chk("prio_id2", 32'(irq_id), 2);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    rd(2'd2, d); chk("prio_pend_left", d, 32'h20);
    eoi = 1'b1; tick(); eoi = 1'b0;
    chk("prio_gap_low", 32'(ir_in), 0);
    tick();
    chk("prio_next_ir", 32'(ir_in), 1);
    chk("prio_id5", 32'(irq_id), 5);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    rd(2'd2, d); chk("prio_pend_empty", d, 0);

    // Level source 0 and withdrawal.
    wr(2'd1, 32'h00); wr(2'd0, 32'h01);
    irq_src = 8'h01; ticks(3);
    chk("lvl_ir_in", 32'(ir_in), 1);
    chk("lvl_irq_id", 32'(irq_id), 0);
    irq_src = '0; ticks(2);
    chk("lvl_still_req", 32'(ir_in), 1);
    tick();
    chk("lvl_withdrawn", 32'(ir_in), 0);
    rd(2'd3, d); chk("lvl_idle", 32'(d[31:30]), 0);

    // Mask gating, W1C, set beats clear.
    wr(2'd0, 32'h00); wr(2'd1, 32'h40);
    irq_src = 8'h40; tick(); irq_src = '0;
    ticks(2);
    rd(2'd2, d); chk("gate_pend", d, 32'h40);
    ticks(2);
    chk("gate_ir_low", 32'(ir_in), 0);
    wr(2'd2, 32'h40);
    rd(2'd2, d); chk("w1c_clear", d, 0);
    irq_src = 8'h40; tick(); irq_src = '0;
    tick();
    wr(2'd2, 32'h40);
    rd(2'd2, d); chk("set_beats_w1c", d, 32'h40);

    // Spurious handshakes.
    eoi = 1'b1; tick(); eoi = 1'b0;
    rd(2'd3, d); chk("spur_eoi_state", 32'(d[31:30]), 0);
    rd(2'd2, d); chk("spur_eoi_pend", d, 32'h40);
    wr(2'd0, 32'h40); tick();
    chk("svc_setup_ir", 32'(ir_in), 1);
    chk("svc_setup_id", 32'(irq_id), 6);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    irq_src = 8'h40; tick(); irq_src = '0;
    ticks(2);
    rd(2'd2, d); chk("nested_pend", d, 32'h40);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    rd(2'd3, d); chk("spur_ack_cause", d, 32'h4000_0006);
    rd(2'd2, d); chk("spur_ack_pend", d, 32'h40);
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    chk("re_req_ir", 32'(ir_in), 1);

    // Asynchronous reset in the middle of a REQ cycle.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("areset_ir_in", 32'(ir_in), 0);
    chk("areset_irq_id", 32'(irq_id), 0);
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d);
      chk($sformatf("areset_reg%0d", a), d, 0);
    end
    tick();
    rst = 1'b0;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      irq_src   = irq_src ^ N'($urandom & $urandom & $urandom);
      cfg_we    = ($urandom_range(15) == 0);
      cfg_addr  = 2'($urandom_range(3));
      cfg_wdata = $urandom;
      ir_ack    = (m_state == REQ) ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      eoi       = (m_state == SVC) ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);
      tick();
      chk("rnd_ir_in", 32'(ir_in), 32'(m_state == REQ));
      chk("rnd_irq_id", 32'(irq_id), 32'(m_id));
      chk("rnd_rdata", cfg_rdata, m_read(cfg_addr));
    end
    cfg_we = 1'b0; ir_ack = 1'b0; eoi = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_ctrl.md
# irq_ctrl

Multi-source interrupt controller that sits directly upstream of the CP0 block. It synchronises N raw interrupt lines and latches edge or level requests into a pending register, then applies a software mask. It priority-encodes the result and presents one clean, registered request level on `ir_in` to CP0. A three-state handshake uses CP0's `ir` (taken) and ERET (end-of-interrupt) so that every serviced interrupt produces exactly one fresh rising edge toward CP0.

## Interface
- `N_SRC`, default 8, number of interrupt sources (2..16).
- `SYNC_STAGES`, default 2, synchroniser depth per source (>=2).

- `clk`  in  1  main clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `irq_src`  in  N_SRC  raw asynchronous interrupt lines.
- `cfg_we`  in  1  config write strobe.
- `cfg_addr`  in  2  register select: 0 MASK, 1 MODE, 2 PENDING, 3 CAUSE.
- `cfg_wdata`  in  32  write data, low N_SRC bits used.
- `cfg_rdata`  out  32  combinational read of `cfg_addr`, zero-extended.
- `ir_ack`  in  1  one-cycle pulse, CP0 has taken the interrupt (its `ir`).
- `eoi`  in  1  one-cycle pulse, ERET executed.
- `ir_in`  out  1  registered request level to CP0.
- `irq_id`  out  4  index of the presented or in-service source.

## Operation
- Synchroniser: `SYNC_STAGES` flops per line. `sync[i]` is the last stage and `prev[i]` is `sync[i]` delayed by one cycle.
- MODE[i]=1 selects edge mode:
  - PEND[i] is set on `sync[i] & ~prev[i]`.
  - PEND[i] is cleared by a write of 1 to PENDING bit i, or by `ir_ack` while `irq_id`==i.
  - When set and clear occur in the same cycle, set wins.
- MODE[i]=0 selects level mode: PEND[i]=`sync[i]`. Writes and acks do not affect it.
- `active` = PEND & MASK. The winner is the lowest set index.
- MASK and MODE are read/write. PENDING reads return PEND and writes are W1C on edge bits. CAUSE is read-only: bit31=`ir_in`, bit30=state==SERVICE, bits3:0=`irq_id`. Writes to CAUSE are ignored.
- FSM states:
  - IDLE: `ir_in`=0. If `active`!=0, go to REQ and register `irq_id`=winner.
  - REQ: `ir_in`=1.
    - `ir_ack` moves to SERVICE.
    - Otherwise, if `active`==0 (request withdrawn or masked), return to IDLE.
    - `irq_id` re-tracks the winner each cycle while in REQ.
  - SERVICE: `ir_in`=0. `irq_id` is held. `eoi` moves to IDLE. Nested requests only accumulate in PEND.
- The FSM always passes through IDLE for at least one cycle with `ir_in`=0 between two requests. This guarantees CP0 sees a new rising edge.
- Ignored inputs: `ir_ack` outside REQ and `eoi` outside SERVICE.
- `ir_ack` and `eoi` in the same cycle: only the event matching the current state applies.

## Timing
- Reset, asynchronous: all sync and prev flops 0, PEND 0, MASK 0, MODE 0, state IDLE, `ir_in`=0, `irq_id`=0. `cfg_rdata` follows the reset registers.
- Reset asserted mid-operation, including in REQ or SERVICE, returns immediately to IDLE with all outputs 0 and all pending requests lost.
- Latency: a raw edge setting `sync` at edge k (SYNC_STAGES=2: raw sampled at k-1) sets PEND at k+1 and drives `ir_in`=1 at k+2.
  - Total: SYNC_STAGES+2 edges from the first sampling edge to `ir_in`.
- `ir_ack` at edge j: state is SERVICE and `ir_in`=0 after j; PEND bit cleared at j.
- `eoi` at edge j: state is IDLE after j. Earliest re-assertion of `ir_in` is after j+1.
- Config writes take effect at the next edge. A MASK write clearing the presented source while in REQ drops `ir_in` one cycle later.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle -> `ir_in`=0, `irq_id`=0, and reads of MASK/MODE/PENDING/CAUSE all 0, before the next clock edge.
- Edge source: MASK=0x08, MODE=0x08, pulse `irq_src[3]` -> `ir_in`=1 four edges later with `irq_id`=3. Then `ir_ack` -> `ir_in`=0 and PENDING=0. Then `eoi` -> IDLE.
- Priority and nesting: MASK=0xFF, MODE=0xFF, raise sources 5 and 2 together -> `irq_id`=2. After ack and eoi, `ir_in` is 0 for exactly one cycle, then 1 with `irq_id`=5.
- Level source and withdrawal: MODE=0, MASK=0x01, hold `irq_src[0]` -> REQ. Drop it before ack -> `ir_in` returns to 0 three edges after the drop (SYNC_STAGES+1), and state is IDLE.
- Mask gating and W1C: with MASK=0, edge on source 6 -> PENDING=0x40 and `ir_in` stays 0. Write PENDING=0x40 -> PENDING=0. Edge plus W1C in the same cycle -> bit stays set.
- Spurious handshake: `eoi` in IDLE and `ir_ack` in SERVICE -> no state change and no PEND change.
